// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encoding,
// constant helpers and the parameter legality rule.
package mod_updown_counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned      r;
    longint unsigned  x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned     width,
                                   input longint unsigned modulus,
                                   input int unsigned     prescale);
    return (width >= 1) && (width <= 32) &&
           (modulus >= 2) && (modulus <= (64'd1 << width)) &&
           (prescale >= 1) && (prescale <= 65536);
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of one counter stage; the counter is the slave side.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             carry_out;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  q, tc, carry_out, wrap, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output q, tc, carry_out, wrap, load_err
  );
endinterface

// File: rtl/mod_updown_counter_prescaler_tick.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each period.
module mod_updown_counter_prescaler_tick
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk, reset, sync_clr};
    assign tick     = en;
  end else begin : g_count
    localparam int unsigned    PW   = clog2(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_psc;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_psc <= '0;
      end else if (sync_clr) begin
        r_psc <= '0;
      end else if (en) begin
        r_psc <= (r_psc == LAST) ? '0 : r_psc + PW'(1);
      end
    end

    assign tick = en & (r_psc == LAST);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with prescaler, clear, checked load,
// terminal count and cascade carry.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_updown_counter_if.slave  bus
);

  if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  // LAST is all-ones when MODULUS == 2**WIDTH, so one compare covers both cases.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);

  logic             w_tick;
  logic             w_sync_clr;
  logic             w_at_last;
  logic             w_at_zero;
  logic             w_load_ok;
  logic             w_tc;
  dir_e             w_dir;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_load_err;

  assign w_sync_clr = bus.clr | bus.load;
  assign w_dir      = dir_e'(bus.up_dn);
  assign w_at_last  = (r_q == LAST);
  assign w_at_zero  = (r_q == '0);
  assign w_load_ok  = (bus.load_val <= LAST);
  assign w_tc       = (w_dir == DIR_UP) ? w_at_last : w_at_zero;

  mod_updown_counter_prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_psc (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .sync_clr (w_sync_clr),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (bus.clr) begin
        r_q <= '0;
      end else if (bus.load) begin
        r_q        <= w_load_ok ? bus.load_val : LAST;
        r_load_err <= ~w_load_ok;
      end else if (w_tick) begin
        if (w_dir == DIR_UP) begin
          r_q    <= w_at_last ? '0 : r_q + WIDTH'(1);
          r_wrap <= w_at_last;
        end else begin
          r_q    <= w_at_zero ? LAST : r_q - WIDTH'(1);
          r_wrap <= w_at_zero;
        end
      end
    end
  end

  assign bus.q         = r_q;
  assign bus.tc        = w_tc;
  assign bus.carry_out = w_tc & w_tick;
  assign bus.wrap      = r_wrap;
  assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: five stages (two of them cascaded) checked every
// cycle against an arithmetic model, plus directed literal checks.
module tb_mod_updown_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  mod_updown_counter_if #(.WIDTH(4)) a_if ();
  mod_updown_counter_if #(.WIDTH(4)) p_if ();
  mod_updown_counter_if #(.WIDTH(4)) f_if ();
  mod_updown_counter_if #(.WIDTH(4)) c0_if ();
  mod_updown_counter_if #(.WIDTH(4)) c1_if ();

  assign c1_if.en = c0_if.carry_out;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a
    (.clk(clk), .reset(rst_n), .bus(a_if));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_p
    (.clk(clk), .reset(rst_n), .bus(p_if));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(2)) u_f
    (.clk(clk), .reset(rst_n), .bus(f_if));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_c0
    (.clk(clk), .reset(rst_n), .bus(c0_if));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_c1
    (.clk(clk), .reset(rst_n), .bus(c1_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0=a, 1=p, 2=f, 3=c0, 4=c1 (en of c1 is c0's carry)
  string nm [5] = '{"a", "p", "f", "c0", "c1"};
  int    mm [5] = '{10, 10, 16, 10, 10};
  int    mp [5] = '{1, 3, 2, 1, 1};
  int    mq [5];
  int    mpsc [5];
  bit    mwrap [5];
  bit    mlerr [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_tc(input int k, input bit up);
    return up ? (mq[k] == mm[k] - 1) : (mq[k] == 0);
  endfunction

  function automatic void get_in(input int k, output bit en, output bit up,
                                 output bit clr, output bit ld, output int lv);
    bit e0, u0, c0, l0;
    int v0;
    case (k)
      0: begin en = a_if.en;  up = a_if.up_dn;  clr = a_if.clr;  ld = a_if.load;  lv = int'(a_if.load_val);  end
      1: begin en = p_if.en;  up = p_if.up_dn;  clr = p_if.clr;  ld = p_if.load;  lv = int'(p_if.load_val);  end
      2: begin en = f_if.en;  up = f_if.up_dn;  clr = f_if.clr;  ld = f_if.load;  lv = int'(f_if.load_val);  end
      3: begin en = c0_if.en; up = c0_if.up_dn; clr = c0_if.clr; ld = c0_if.load; lv = int'(c0_if.load_val); end
      default: begin
        get_in(3, e0, u0, c0, l0, v0);
        en  = m_tc(3, u0) && e0 && (mpsc[3] == mp[3] - 1);
        up  = c1_if.up_dn; clr = c1_if.clr; ld = c1_if.load; lv = int'(c1_if.load_val);
      end
    endcase
  endfunction

  initial forever begin
    bit en [5], up [5], clr [5], ld [5];
    int lv [5];
    bit tick;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        mq[k] = 0; mpsc[k] = 0; mwrap[k] = 0; mlerr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 5; k++) get_in(k, en[k], up[k], clr[k], ld[k], lv[k]);
      for (int k = 0; k < 5; k++) begin
        tick = en[k] && (mpsc[k] == mp[k] - 1);
        mwrap[k] = 0;
        mlerr[k] = 0;
        if (clr[k]) begin
          mq[k] = 0; mpsc[k] = 0;
        end else if (ld[k]) begin
          mpsc[k] = 0;
          if (lv[k] < mm[k]) mq[k] = lv[k];
          else begin mq[k] = mm[k] - 1; mlerr[k] = 1; end
        end else begin
          if (en[k]) mpsc[k] = (mpsc[k] + 1) % mp[k];
          if (tick && up[k]) begin
            mwrap[k] = (mq[k] + 1 == mm[k]);
            mq[k]    = (mq[k] + 1) % mm[k];
          end else if (tick) begin
            mwrap[k] = (mq[k] == 0);
            mq[k]    = (mq[k] + mm[k] - 1) % mm[k];
          end
        end
      end
    end
  end

  initial forever begin
    bit en, up, clr, ld, tc;
    int lv;
    logic [31:0] act [5];
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < 5; k++) begin
        get_in(k, en, up, clr, ld, lv);
        tc = m_tc(k, up);
        case (k)
          0: act = '{32'(a_if.q),  32'(a_if.tc),  32'(a_if.carry_out),  32'(a_if.wrap),  32'(a_if.load_err)};
          1: act = '{32'(p_if.q),  32'(p_if.tc),  32'(p_if.carry_out),  32'(p_if.wrap),  32'(p_if.load_err)};
          2: act = '{32'(f_if.q),  32'(f_if.tc),  32'(f_if.carry_out),  32'(f_if.wrap),  32'(f_if.load_err)};
          3: act = '{32'(c0_if.q), 32'(c0_if.tc), 32'(c0_if.carry_out), 32'(c0_if.wrap), 32'(c0_if.load_err)};
          default: act = '{32'(c1_if.q), 32'(c1_if.tc), 32'(c1_if.carry_out), 32'(c1_if.wrap), 32'(c1_if.load_err)};
        endcase
        chk({nm[k], ".q"},        act[0], 32'(mq[k]));
        chk({nm[k], ".tc"},       act[1], 32'(tc));
        chk({nm[k], ".carry"},    act[2], 32'(tc && en && (mpsc[k] == mp[k] - 1)));
        chk({nm[k], ".wrap"},     act[3], 32'(mwrap[k]));
        chk({nm[k], ".load_err"}, act[4], 32'(mlerr[k]));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rnd(output logic en, output logic up, output logic clr,
                     output logic ld, output logic [3:0] lv);
    en  = ($urandom_range(0, 3) != 0);
    up  = $urandom_range(0, 1) == 1;
    clr = ($urandom_range(0, 31) == 0);
    ld  = ($urandom_range(0, 15) == 0);
    lv  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    {a_if.en, a_if.up_dn, a_if.clr, a_if.load, a_if.load_val} = '0;
    {p_if.en, p_if.up_dn, p_if.clr, p_if.load, p_if.load_val} = '0;
    {f_if.en, f_if.up_dn, f_if.clr, f_if.load, f_if.load_val} = '0;
    {c0_if.en, c0_if.up_dn, c0_if.clr, c0_if.load, c0_if.load_val} = '0;
    {c1_if.up_dn, c1_if.clr, c1_if.load, c1_if.load_val} = '0;
    edges(2);
    chk("reset.q", 32'(a_if.q), 0);
    chk("reset.wrap", 32'(a_if.wrap), 0);
    chk("reset.load_err", 32'(a_if.load_err), 0);

    // Count up through the modulus
    rst_n = 1'b1;
    a_if.en = 1'b1; a_if.up_dn = 1'b1;
    edges(9);
    chk("up.q9", 32'(a_if.q), 9);
    chk("up.tc9", 32'(a_if.tc), 1);
    edges(1);
    chk("up.wrap_q", 32'(a_if.q), 0);
    chk("up.wrap", 32'(a_if.wrap), 1);
    edges(2);
    chk("up.q2", 32'(a_if.q), 2);
    chk("up.wrap_gone", 32'(a_if.wrap), 0);

    // Count down from zero
    a_if.clr = 1'b1;
    edges(1);
    chk("clr.q", 32'(a_if.q), 0);
    a_if.clr = 1'b0; a_if.up_dn = 1'b0;
    #1 chk("dn.tc0", 32'(a_if.tc), 1);
    edges(1);
    chk("dn.q9", 32'(a_if.q), 9);
    chk("dn.wrap", 32'(a_if.wrap), 1);
    edges(1);
    chk("dn.q8", 32'(a_if.q), 8);

    // clr beats load; out-of-range load saturates
    a_if.clr = 1'b1; a_if.load = 1'b1; a_if.load_val = 4'd5;
    edges(1);
    chk("clrld.q", 32'(a_if.q), 0);
    chk("clrld.load_err", 32'(a_if.load_err), 0);
    a_if.clr = 1'b0; a_if.load_val = 4'd12; a_if.en = 1'b0;
    edges(1);
    chk("badld.q", 32'(a_if.q), 9);
    chk("badld.load_err", 32'(a_if.load_err), 1);
    a_if.load = 1'b0; a_if.en = 1'b1; a_if.up_dn = 1'b1;
    edges(1);
    chk("badld.next_q", 32'(a_if.q), 0);
    chk("badld.next_wrap", 32'(a_if.wrap), 1);
    chk("badld.err_gone", 32'(a_if.load_err), 0);
    a_if.en = 1'b0;

    // Prescale by 3 with en dropped for 2 cycles
    p_if.clr = 1'b1;
    edges(1);
    p_if.clr = 1'b0; p_if.en = 1'b1; p_if.up_dn = 1'b1;
    edges(2);
    chk("psc.q_e2", 32'(p_if.q), 0);
    edges(1);
    chk("psc.q_e3", 32'(p_if.q), 1);
    p_if.en = 1'b0;
    edges(2);
    p_if.en = 1'b1;
    edges(2);
    chk("psc.q_stretched", 32'(p_if.q), 1);
    edges(1);
    chk("psc.q_e8", 32'(p_if.q), 2);
    p_if.en = 1'b0;

    // Two-stage decimal cascade
    c0_if.clr = 1'b1; c1_if.clr = 1'b1;
    edges(1);
    c0_if.clr = 1'b0; c1_if.clr = 1'b0;
    c0_if.en = 1'b1; c0_if.up_dn = 1'b1; c1_if.up_dn = 1'b1;
    edges(57);
    chk("cas.57", 32'(c1_if.q) * 10 + 32'(c0_if.q), 57);
    edges(43);
    chk("cas.100", 32'(c1_if.q) * 10 + 32'(c0_if.q), 0);
    chk("cas.100_wrap", 32'(c1_if.wrap), 1);
    edges(15);
    chk("cas.15", 32'(c1_if.q) * 10 + 32'(c0_if.q), 15);
    #2 rst_n = 1'b0;
    #1;
    chk("async.c0_q", 32'(c0_if.q), 0);
    chk("async.c1_q", 32'(c1_if.q), 0);
    chk("async.p_q", 32'(p_if.q), 0);
    edges(1);
    rst_n = 1'b1;

    // Random traffic on every stage
    repeat (3000) begin
      rnd(a_if.en, a_if.up_dn, a_if.clr, a_if.load, a_if.load_val);
      rnd(p_if.en, p_if.up_dn, p_if.clr, p_if.load, p_if.load_val);
      rnd(f_if.en, f_if.up_dn, f_if.clr, f_if.load, f_if.load_val);
      rnd(c0_if.en, c0_if.up_dn, c0_if.clr, c0_if.load, c0_if.load_val);
      c1_if.up_dn    = $urandom_range(0, 1) == 1;
      c1_if.clr      = ($urandom_range(0, 63) == 0);
      c1_if.load     = ($urandom_range(0, 31) == 0);
      c1_if.load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      edges(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
